// File: rtl/raxi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raxi_pkg
//  Description : Shared definitions for the AXI4-Lite to RAXI bridge:
//                AXI response codes, bridge and engine state encodings,
//                the default RAXI window base and the window-match helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package raxi_pkg;

    // AXI response codes carried on s_bresp / s_rresp.
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Default base of the RAXI register window.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FF00;

    // Bridge FSM encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_W_REQ  = 3'd1;
    localparam logic [2:0] ST_W_ACK  = 3'd2;
    localparam logic [2:0] ST_B_RESP = 3'd3;
    localparam logic [2:0] ST_R_REQ  = 3'd4;
    localparam logic [2:0] ST_R_ACK  = 3'd5;
    localparam logic [2:0] ST_R_RESP = 3'd6;

    // Transaction engine phase encoding.
    localparam logic [1:0] ENG_IDLE = 2'd0;
    localparam logic [1:0] ENG_REQ  = 2'd1;
    localparam logic [1:0] ENG_ACK  = 2'd2;

    // True when the upper address bits above the window size match the base.
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned win_bits
    );
        return (addr >> win_bits) == (base >> win_bits);
    endfunction

endpackage : raxi_pkg
`default_nettype wire

// File: rtl/raxi_txn_engine.sv
`default_nettype none
// ============================================================================
//  Module      : raxi_txn_engine
//  Description : Runs one RAXI read or write as a four-phase valid/ready
//                handshake with a per-phase ready timeout.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n      : clock, synchronous active-low reset
//    start           : launch a transaction (only honoured while idle)
//    is_write        : 1 = write, 0 = read
//    addr, wdata     : transaction address and write data
//    acked           : ready seen high while requesting (REQ -> ACK this edge)
//    done, err       : transaction completes this edge; err = timed out
//    rdata           : read data captured at the ready edge (0 until then)
//    raxi_*          : RAXI master side
// ============================================================================
module raxi_txn_engine
    import raxi_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        acked,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        raxi_rvalid,
    output logic        raxi_wvalid,
    input  logic        raxi_ready,
    output logic [31:0] raxi_address,
    output logic [31:0] raxi_wdata,
    input  logic [31:0] raxi_rdata
);

    // The counter is cleared on phase entry, so the edge at which it would
    // reach TIMEOUT is the one where it currently holds TIMEOUT-1.
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] r_phase;
    logic [7:0] r_cnt;
    logic       w_tmo;

    always_comb begin
        w_tmo = (r_cnt == c_TMO_LAST);
        acked = (r_phase == ENG_REQ) && raxi_ready;
        done  = 1'b0;
        err   = 1'b0;
        if ((r_phase == ENG_REQ) && !raxi_ready && w_tmo) begin
            done = 1'b1;
            err  = 1'b1;
        end else if (r_phase == ENG_ACK) begin
            if (!raxi_ready) begin
                done = 1'b1;
            end else if (w_tmo) begin
                done = 1'b1;
                err  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase      <= ENG_IDLE;
            r_cnt        <= 8'd0;
            rdata        <= 32'd0;
            raxi_rvalid  <= 1'b0;
            raxi_wvalid  <= 1'b0;
            raxi_address <= 32'd0;
            raxi_wdata   <= 32'd0;
        end else begin
            case (r_phase)
                ENG_IDLE: begin
                    if (start) begin
                        r_phase      <= ENG_REQ;
                        r_cnt        <= 8'd0;
                        raxi_wvalid  <= is_write;
                        raxi_rvalid  <= !is_write;
                        raxi_address <= addr;
                        // Cleared so a read that times out before ready
                        // reports zero data.
                        rdata        <= 32'd0;
                        if (is_write) begin
                            raxi_wdata <= wdata;
                        end
                    end
                end
                ENG_REQ: begin
                    if (raxi_ready) begin
                        r_phase     <= ENG_ACK;
                        r_cnt       <= 8'd0;
                        raxi_wvalid <= 1'b0;
                        raxi_rvalid <= 1'b0;
                        if (raxi_rvalid) begin
                            rdata <= raxi_rdata;
                        end
                    end else if (w_tmo) begin
                        r_phase     <= ENG_IDLE;
                        raxi_wvalid <= 1'b0;
                        raxi_rvalid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ENG_ACK: begin
                    if (done) begin
                        r_phase <= ENG_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_phase <= ENG_IDLE;
                end
            endcase
        end
    end

endmodule : raxi_txn_engine
`default_nettype wire

// File: rtl/axi_lite_to_raxi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_to_raxi_bridge
//  Description : Accepts AXI4-Lite reads/writes, checks the address window
//                and byte strobes, arbitrates read vs write and replays each
//                transaction as one RAXI handshake, then returns the response.
//  Revision    : 1.0 - initial release
//
//  Ports
//    iclk, RESETn          : clock, synchronous active-low reset
//    s_aw*/s_w*/s_b*       : AXI4-Lite write address, data and response
//    s_ar*/s_r*            : AXI4-Lite read address and data/response
//    raxi_rvalid/wvalid    : RAXI read/write request
//    raxi_ready            : RAXI slave done
//    raxi_address/wdata    : RAXI address and write data
//    raxi_rdata            : RAXI read data
// ============================================================================
module axi_lite_to_raxi_bridge
    import raxi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned WIN_BITS  = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        iclk,
    input  logic        RESETn,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        raxi_rvalid,
    output logic        raxi_wvalid,
    input  logic        raxi_ready,
    output logic [31:0] raxi_address,
    output logic [31:0] raxi_wdata,
    input  logic [31:0] raxi_rdata
);

    logic [2:0]  r_state;
    // Held low through reset and one edge after, so the readies are 0 while
    // reset is applied.
    logic        r_run;
    // 1 when the most recent read/write contention was won by the write.
    // Resets to 1 so the read wins the first contention.
    logic        r_last_wr;
    logic        r_aw_vld;
    logic        r_w_vld;
    logic        r_ar_vld;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_araddr;

    logic        w_wr_pend;
    logic        w_rd_pend;
    logic        w_grant_rd;
    logic        w_grant_wr;
    logic        w_wr_in_win;
    logic        w_rd_in_win;
    logic        w_start;
    logic        w_eng_acked;
    logic        w_eng_done;
    logic        w_eng_err;
    logic [31:0] w_eng_rdata;

    assign s_awready = r_run && (r_state == ST_IDLE) && !r_aw_vld;
    assign s_wready  = r_run && (r_state == ST_IDLE) && !r_w_vld;
    assign s_arready = r_run && (r_state == ST_IDLE) && !r_ar_vld;

    assign w_wr_pend   = r_aw_vld && r_w_vld;
    assign w_rd_pend   = r_ar_vld;
    assign w_grant_rd  = w_rd_pend && (!w_wr_pend || r_last_wr);
    assign w_grant_wr  = w_wr_pend && !w_grant_rd;
    assign w_wr_in_win = addr_in_window(r_awaddr, BASE_ADDR, WIN_BITS);
    assign w_rd_in_win = addr_in_window(r_araddr, BASE_ADDR, WIN_BITS);
    assign w_start     = (r_state == ST_IDLE) &&
                         ((w_grant_rd && w_rd_in_win) ||
                          (w_grant_wr && w_wr_in_win && (r_wstrb == 4'hF)));

    raxi_txn_engine #(
        .TIMEOUT (TIMEOUT)
    ) u_engine (
        .clk          (iclk),
        .rst_n        (RESETn),
        .start        (w_start),
        .is_write     (w_grant_wr),
        .addr         (w_grant_wr ? r_awaddr : r_araddr),
        .wdata        (r_wdata),
        .acked        (w_eng_acked),
        .done         (w_eng_done),
        .err          (w_eng_err),
        .rdata        (w_eng_rdata),
        .raxi_rvalid  (raxi_rvalid),
        .raxi_wvalid  (raxi_wvalid),
        .raxi_ready   (raxi_ready),
        .raxi_address (raxi_address),
        .raxi_wdata   (raxi_wdata),
        .raxi_rdata   (raxi_rdata)
    );

    always_ff @(posedge iclk) begin
        if (!RESETn) begin
            r_state   <= ST_IDLE;
            r_run     <= 1'b0;
            r_last_wr <= 1'b1;
            r_aw_vld  <= 1'b0;
            r_w_vld   <= 1'b0;
            r_ar_vld  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_araddr  <= 32'd0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            s_rvalid  <= 1'b0;
            s_rresp   <= 2'b00;
            s_rdata   <= 32'd0;
        end else begin
            r_run <= 1'b1;

            // Channel latches; readies are only high in IDLE, so these never
            // collide with the clears done in the response states.
            if (s_awvalid && s_awready) begin
                r_aw_vld <= 1'b1;
                r_awaddr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                r_w_vld <= 1'b1;
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end
            if (s_arvalid && s_arready) begin
                r_ar_vld <= 1'b1;
                r_araddr <= s_araddr;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_rd) begin
                        if (w_wr_pend) begin
                            r_last_wr <= 1'b0;
                        end
                        if (w_rd_in_win) begin
                            r_state <= ST_R_REQ;
                        end else begin
                            s_rresp  <= RESP_DECERR;
                            s_rdata  <= 32'd0;
                            s_rvalid <= 1'b1;
                            r_state  <= ST_R_RESP;
                        end
                    end else if (w_grant_wr) begin
                        if (w_rd_pend) begin
                            r_last_wr <= 1'b1;
                        end
                        if (!w_wr_in_win) begin
                            s_bresp  <= RESP_DECERR;
                            s_bvalid <= 1'b1;
                            r_state  <= ST_B_RESP;
                        end else if (r_wstrb != 4'hF) begin
                            s_bresp  <= RESP_SLVERR;
                            s_bvalid <= 1'b1;
                            r_state  <= ST_B_RESP;
                        end else begin
                            r_state <= ST_W_REQ;
                        end
                    end
                end
                ST_W_REQ, ST_W_ACK: begin
                    if (w_eng_done) begin
                        s_bresp  <= w_eng_err ? RESP_SLVERR : RESP_OKAY;
                        s_bvalid <= 1'b1;
                        r_state  <= ST_B_RESP;
                    end else if (w_eng_acked) begin
                        r_state <= ST_W_ACK;
                    end
                end
                ST_B_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        r_aw_vld <= 1'b0;
                        r_w_vld  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_R_REQ, ST_R_ACK: begin
                    if (w_eng_done) begin
                        // Engine data is zero for a request-phase timeout and
                        // holds the captured word once ready was seen.
                        s_rresp  <= w_eng_err ? RESP_SLVERR : RESP_OKAY;
                        s_rdata  <= w_eng_rdata;
                        s_rvalid <= 1'b1;
                        r_state  <= ST_R_RESP;
                    end else if (w_eng_acked) begin
                        r_state <= ST_R_ACK;
                    end
                end
                ST_R_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        r_ar_vld <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : axi_lite_to_raxi_bridge
`default_nettype wire

// File: tb/tb_axi_lite_to_raxi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_to_raxi_bridge
//  Description : Directed bench for the AXI4-Lite to RAXI bridge with a
//                zero-wait RAXI slave stub that can be told to hang.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_to_raxi_bridge;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic        iclk;
    logic        RESETn;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        raxi_rvalid, raxi_wvalid, raxi_ready;
    logic [31:0] raxi_address, raxi_wdata, raxi_rdata;

    logic        slave_hang;
    logic [31:0] mem [0:63];

    int          n_assert;
    int          n_fail;
    int          n_wv_rise;
    int          n_rv_rise;
    int          n_excl;
    logic        p_wv;
    logic        p_rv;
    logic [31:0] last_waddr;

    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];

    axi_lite_to_raxi_bridge #(
        .TIMEOUT (16)
    ) dut (
        .iclk         (iclk),
        .RESETn       (RESETn),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_awaddr     (s_awaddr),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_bresp      (s_bresp),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_araddr     (s_araddr),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .raxi_rvalid  (raxi_rvalid),
        .raxi_wvalid  (raxi_wvalid),
        .raxi_ready   (raxi_ready),
        .raxi_address (raxi_address),
        .raxi_wdata   (raxi_wdata),
        .raxi_rdata   (raxi_rdata)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Zero-wait four-phase RAXI slave backed by a small memory.
    always @(posedge iclk) begin
        if (!RESETn) begin
            raxi_ready <= 1'b0;
            raxi_rdata <= 32'd0;
        end else if (!slave_hang) begin
            if ((raxi_wvalid || raxi_rvalid) && !raxi_ready) begin
                raxi_ready <= 1'b1;
                if (raxi_wvalid) mem[raxi_address[7:2]] <= raxi_wdata;
                else             raxi_rdata <= mem[raxi_address[7:2]];
            end else if (!(raxi_wvalid || raxi_rvalid) && raxi_ready) begin
                raxi_ready <= 1'b0;
            end
        end
    end

    // RAXI activity monitor.
    always @(posedge iclk) begin
        p_wv <= raxi_wvalid;
        p_rv <= raxi_rvalid;
        if (raxi_wvalid && !p_wv) begin
            n_wv_rise  <= n_wv_rise + 1;
            last_waddr <= raxi_address;
        end
        if (raxi_rvalid && !p_rv) n_rv_rise <= n_rv_rise + 1;
        if (raxi_wvalid && raxi_rvalid) n_excl <= n_excl + 1;
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present any mix of AW, W and AR together; each valid drops once its
    // handshake edge has passed.
    task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [31:0] awaddr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] araddr);
        bit aw_r, w_r, ar_r, ok;
        s_awvalid = do_aw; s_awaddr = awaddr;
        s_wvalid  = do_w;  s_wdata  = wdata; s_wstrb = wstrb;
        s_arvalid = do_ar; s_araddr = araddr;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            aw_r = s_awready; w_r = s_wready; ar_r = s_arready;
            tick();
            if (aw_r) s_awvalid = 1'b0;
            if (w_r)  s_wvalid  = 1'b0;
            if (ar_r) s_arvalid = 1'b0;
            if (!s_awvalid && !s_wvalid && !s_arvalid) begin
                ok = 1'b1;
                break;
            end
        end
        check("handshake_done", 32'(ok), 32'd1);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    endtask

    task automatic collect_b(input string tag);
        bit ok;
        logic [1:0] e;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (s_bvalid) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, "_bwait"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_bq"}, 32'(exp_b.size() > 0), 32'd1);
            e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'b01;
            check({tag, "_bresp"}, 32'(s_bresp), 32'(e));
            s_bready = 1'b1;
            tick();
            s_bready = 1'b0;
            check({tag, "_bdrop"}, 32'(s_bvalid), 32'd0);
        end
    endtask

    task automatic collect_r(input string tag);
        bit ok;
        rexp_t e;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (s_rvalid) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, "_rwait"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_rq"}, 32'(exp_r.size() > 0), 32'd1);
            e = (exp_r.size() > 0) ? exp_r.pop_front() : '{resp: 2'b01, data: 32'hBAD0BAD0};
            check({tag, "_rresp"}, 32'(s_rresp), 32'(e.resp));
            check({tag, "_rdata"}, s_rdata, e.data);
            s_rready = 1'b1;
            tick();
            s_rready = 1'b0;
            check({tag, "_rdrop"}, 32'(s_rvalid), 32'd0);
        end
    endtask

    task automatic wait_first(output bit first_rd);
        first_rd = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (s_bvalid || s_rvalid) begin first_rd = s_rvalid; break; end
            tick();
        end
    endtask

    initial begin
        int w0, r0, n;
        bit first_rd;
        n_assert = 0; n_fail = 0;
        n_wv_rise = 0; n_rv_rise = 0; n_excl = 0;
        p_wv = 1'b0; p_rv = 1'b0; last_waddr = 32'd0;
        RESETn = 1'b0; slave_hang = 1'b0;
        s_awvalid = 1'b0; s_awaddr = 32'd0; s_wvalid = 1'b0; s_wdata = 32'd0;
        s_wstrb = 4'd0; s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = 32'd0;
        s_rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_readies", 32'({s_awready, s_wready, s_arready}), 32'd0);
        check("rst_valids", 32'({s_bvalid, s_rvalid, raxi_rvalid, raxi_wvalid}), 32'd0);
        check("rst_addr", raxi_address, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        RESETn = 1'b1;
        tick(); tick();
        check("idle_readies", 32'({s_awready, s_wready, s_arready}), 32'd7);

        // Write then read back, with one-cycle request latency
        w0 = n_wv_rise;
        exp_b.push_back(OKAY);
        issue(1, 1, 0, 32'hFFFF_FF08, 32'hDEAD_BEEF, 4'hF, 32'd0);
        tick();
        check("wr1_latency", 32'(raxi_wvalid), 32'd1);
        check("wr1_addr", raxi_address, 32'hFFFF_FF08);
        check("wr1_wdata", raxi_wdata, 32'hDEAD_BEEF);
        collect_b("wr1");
        check("wr1_pulses", 32'(n_wv_rise - w0), 32'd1);
        check("wr1_paddr", last_waddr, 32'hFFFF_FF08);
        exp_r.push_back('{resp: OKAY, data: 32'hDEAD_BEEF});
        issue(0, 0, 1, 32'd0, 32'd0, 4'h0, 32'hFFFF_FF08);
        collect_r("rd1");

        // W three cycles ahead of AW
        w0 = n_wv_rise;
        issue(0, 1, 0, 32'd0, 32'h1234_5678, 4'hF, 32'd0);
        repeat (3) tick();
        check("wfirst_nowrite", 32'(n_wv_rise - w0), 32'd0);
        exp_b.push_back(OKAY);
        issue(1, 0, 0, 32'hFFFF_FF3C, 32'h1234_5678, 4'hF, 32'd0);
        tick();
        check("wfirst_latency", 32'(raxi_wvalid), 32'd1);
        collect_b("wfirst");
        check("wfirst_pulses", 32'(n_wv_rise - w0), 32'd1);
        exp_r.push_back('{resp: OKAY, data: 32'h1234_5678});
        issue(0, 0, 1, 32'd0, 32'd0, 4'h0, 32'hFFFF_FF3C);
        collect_r("rd3c");

        // Out-of-window read and partial-strobe write never touch RAXI
        r0 = n_rv_rise; w0 = n_wv_rise;
        exp_r.push_back('{resp: DECERR, data: 32'd0});
        issue(0, 0, 1, 32'd0, 32'd0, 4'h0, 32'h0000_1000);
        collect_r("decerr");
        check("decerr_norv", 32'(n_rv_rise - r0), 32'd0);
        exp_b.push_back(SLVERR);
        issue(1, 1, 0, 32'hFFFF_FF08, 32'h0BAD_F00D, 4'b0011, 32'd0);
        collect_b("strb");
        check("strb_nowv", 32'(n_wv_rise - w0), 32'd0);

        // Ready timeout on a hung slave, then recovery
        slave_hang = 1'b1;
        exp_r.push_back('{resp: SLVERR, data: 32'd0});
        issue(0, 0, 1, 32'd0, 32'd0, 4'h0, 32'hFFFF_FF08);
        tick();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!raxi_rvalid) break;
            n++;
            tick();
        end
        check("tmo_cycles", 32'(n), 32'd16);
        collect_r("tmo");
        slave_hang = 1'b0;
        exp_r.push_back('{resp: OKAY, data: 32'hDEAD_BEEF});
        issue(0, 0, 1, 32'd0, 32'd0, 4'h0, 32'hFFFF_FF08);
        collect_r("recover");

        // Contention: read wins first, write wins second
        exp_r.push_back('{resp: OKAY, data: 32'h1234_5678});
        exp_b.push_back(OKAY);
        issue(1, 1, 1, 32'hFFFF_FF20, 32'hA5A5_A5A5, 4'hF, 32'hFFFF_FF3C);
        wait_first(first_rd);
        check("pair1_read_first", 32'(first_rd), 32'd1);
        collect_r("pair1");
        collect_b("pair1");
        exp_b.push_back(OKAY);
        exp_r.push_back('{resp: OKAY, data: 32'hA5A5_A5A5});
        issue(1, 1, 1, 32'hFFFF_FF24, 32'h5A5A_5A5A, 4'hF, 32'hFFFF_FF20);
        wait_first(first_rd);
        check("pair2_read_first", 32'(first_rd), 32'd0);
        collect_b("pair2");
        collect_r("pair2");

        // Reset while a write sits in the request phase
        slave_hang = 1'b1;
        issue(1, 1, 0, 32'hFFFF_FF28, 32'hCAFE_0001, 4'hF, 32'd0);
        tick();
        check("mid_wvalid", 32'(raxi_wvalid), 32'd1);
        RESETn = 1'b0;
        tick();
        check("mid_rst_wvalid", 32'(raxi_wvalid), 32'd0);
        check("mid_rst_rdata", s_rdata, 32'd0);
        check("mid_rst_ready", 32'({s_awready, s_wready, s_arready}), 32'd0);
        RESETn = 1'b1;
        slave_hang = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_bvalid) n++;
            tick();
        end
        check("mid_no_bvalid", 32'(n), 32'd0);
        exp_r.push_back('{resp: OKAY, data: 32'h1234_5678});
        issue(0, 0, 1, 32'd0, 32'd0, 4'h0, 32'hFFFF_FF3C);
        collect_r("post_rst");

        check("sb_empty", 32'(exp_b.size() + exp_r.size()), 32'd0);
        check("exclusive", 32'(n_excl), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_axi_lite_to_raxi_bridge
`default_nettype wire
